// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter.
// Holds the FSM state encoding, read latency, port count, bus widths and
// the per-requester command payload.
package mem_arb_pkg;

  localparam int unsigned NUM_PORTS  = 2;
  localparam int unsigned MEM_RD_LAT = 2;
  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned DATA_W     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    DRAIN = 2'd3
  } arb_state_t;

  // One requester's memory command as seen by the arbiter.
  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Read-return tag pipe: tracks which requester owns each read in flight.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   push_valid    a read was accepted by memory this cycle
//   push_owner    requester that issued it
//   pop_valid     tag emerging together with valid mem_rdata
//   pop_owner     requester that the emerging data belongs to
//   busy_c        any read still in flight
module rd_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = MEM_RD_LAT
) (
  input  logic clk,
  input  logic rst,
  input  logic push_valid,
  input  logic push_owner,
  output logic pop_valid,
  output logic pop_owner,
  output logic busy_c
);

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] own_q;

  // Shift register; reset discards every read in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      own_q <= '0;
    end else begin
      vld_q <= {vld_q[DEPTH-2:0], push_valid};
      own_q <= {own_q[DEPTH-2:0], push_owner};
    end
  end

  assign pop_valid = vld_q[DEPTH-1];
  assign pop_owner = own_q[DEPTH-1];
  assign busy_c    = |vld_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter between instruction cache (port 0) and data cache
// (port 1) in front of a four-bank memory with fixed read latency.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   req0/1                   requester wants the memory (held for a whole burst)
//   rd0/1, wr0/1             command from requester, meaningful while granted
//   addr0/1, wdata0/1        command address / write data
//   gnt0/1                   registered grant, one-hot or zero
//   stall0/1                 command not accepted this cycle
//   rdata0/1, rvalid0/1      registered read return per requester
//   mem_addr, mem_wdata      memory command payload
//   mem_rd, mem_wr           memory command strobes
//   mem_rdata, mem_stall     memory read data (2 cycles after accept), busy
//   err                      registered pulse after a rd+wr command
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              rd0,
  input  logic              rd1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              stall0,
  output logic              stall1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_stall,
  output logic              err
);

  arb_state_t state_q, state_nxt;
  logic       last_gnt_q, last_gnt_nxt;

  mem_cmd_t cmd0, cmd1, cmd_sel;
  logic     own_rd, own_wr, illegal, rd_acc;
  logic     pop_valid, pop_owner, pipe_busy;

  assign cmd0 = '{rd: rd0, wr: wr0, addr: addr0, wdata: wdata0};
  assign cmd1 = '{rd: rd1, wr: wr1, addr: addr1, wdata: wdata1};

  // Route the granted port's command; port 0 payload when nobody is granted.
  always_comb begin
    cmd_sel = cmd0;
    if (gnt1) cmd_sel = cmd1;
  end

  assign own_rd    = (gnt0 | gnt1) & cmd_sel.rd;
  assign own_wr    = (gnt0 | gnt1) & cmd_sel.wr;
  assign illegal   = own_rd & own_wr;
  assign mem_rd    = own_rd & ~own_wr;
  assign mem_wr    = own_wr & ~own_rd;
  assign mem_addr  = cmd_sel.addr;
  assign mem_wdata = cmd_sel.wdata;
  assign rd_acc    = mem_rd & ~mem_stall;

  // Granted port sees memory back-pressure; a non-granted port is held off
  // whenever it presents a command.
  assign stall0 = gnt0 ? mem_stall : (rd0 | wr0);
  assign stall1 = gnt1 ? mem_stall : (rd1 | wr1);

  rd_tag_pipe #(
    .DEPTH (MEM_RD_LAT)
  ) u_rd_tag_pipe (
    .clk        (clk),
    .rst        (rst),
    .push_valid (rd_acc),
    .push_owner (gnt1),
    .pop_valid  (pop_valid),
    .pop_owner  (pop_owner),
    .busy_c     (pipe_busy)
  );

  // Next-state and round-robin pointer.
  always_comb begin
    state_nxt    = state_q;
    last_gnt_nxt = last_gnt_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1) state_nxt = last_gnt_q ? GNT0 : GNT1;
        else if (req0)    state_nxt = GNT0;
        else if (req1)    state_nxt = GNT1;
      end
      GNT0: if (!req0 && !illegal) state_nxt = DRAIN;
      GNT1: if (!req1 && !illegal) state_nxt = DRAIN;
      DRAIN: begin
        // last_gnt_q still names the port that just released the grant.
        if (!pipe_busy) begin
          if (last_gnt_q ? req0 : req1)      state_nxt = last_gnt_q ? GNT0 : GNT1;
          else if (last_gnt_q ? req1 : req0) state_nxt = last_gnt_q ? GNT1 : GNT0;
          else                               state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == GNT0 && state_q != GNT0) last_gnt_nxt = 1'b0;
    if (state_nxt == GNT1 && state_q != GNT1) last_gnt_nxt = 1'b1;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      err        <= 1'b0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      state_q    <= state_nxt;
      last_gnt_q <= last_gnt_nxt;
      gnt0       <= (state_nxt == GNT0);
      gnt1       <= (state_nxt == GNT1);
      err        <= illegal;
      rvalid0    <= pop_valid & ~pop_owner;
      rvalid1    <= pop_valid & pop_owner;
      if (pop_valid && !pop_owner) rdata0 <= mem_rdata;
      if (pop_valid && pop_owner)  rdata1 <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level model (owner / releasing port / list of reads
// with their due cycle).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0, req1, rd0, rd1, wr0, wr1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, stall0, stall1, rvalid0, rvalid1;
  logic [15:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr, mem_stall, err;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .rd0(rd0), .rd1(rd1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .stall0(stall0), .stall1(stall1),
    .rdata0(rdata0), .rdata1(rdata1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall), .err(err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model
  typedef struct {
    int owner;
    int due;
  } rd_rec_t;

  rd_rec_t     pend_q[$];
  int          own, rel, last, cyc, wr_acc_cnt;
  logic [15:0] exp_rdata0, exp_rdata1;
  bit          exp_rv0, exp_rv1, exp_err;

  task automatic model_reset();
    pend_q.delete();
    own = -1; rel = -1; last = 1;
    exp_rdata0 = '0; exp_rdata1 = '0;
    exp_rv0 = 0; exp_rv1 = 0; exp_err = 0;
  endtask

  // Run one clock cycle with the inputs currently driven.
  task automatic step();
    bit          o_rd, o_wr, o_req, e_rd, e_wr, ill, busy, nv0, nv1, x_req, r_req;
    logic [15:0] o_addr, o_wd;
    #1;
    o_rd = 0; o_wr = 0; o_req = 0; o_addr = '0; o_wd = '0;
    if (own == 0) begin o_rd = rd0; o_wr = wr0; o_req = req0; o_addr = addr0; o_wd = wdata0; end
    if (own == 1) begin o_rd = rd1; o_wr = wr1; o_req = req1; o_addr = addr1; o_wd = wdata1; end
    ill  = o_rd && o_wr;
    e_rd = o_rd && !o_wr;
    e_wr = o_wr && !o_rd;
    check("mem_rd", mem_rd, e_rd);
    check("mem_wr", mem_wr, e_wr);
    if (e_rd || e_wr) check("mem_addr", mem_addr, o_addr);
    if (e_wr) check("mem_wdata", mem_wdata, o_wd);
    check("stall0", stall0, (own == 0) ? mem_stall : (rd0 | wr0));
    check("stall1", stall1, (own == 1) ? mem_stall : (rd1 | wr1));
    if (mem_wr && !mem_stall) wr_acc_cnt++;

    busy = 0;
    foreach (pend_q[i]) if (pend_q[i].due >= cyc) busy = 1;
    nv0 = 0; nv1 = 0;
    for (int i = pend_q.size() - 1; i >= 0; i--) begin
      if (pend_q[i].due == cyc) begin
        if (pend_q[i].owner == 0) begin nv0 = 1; exp_rdata0 = mem_rdata; end
        else begin nv1 = 1; exp_rdata1 = mem_rdata; end
        pend_q.delete(i);
      end
    end
    if (e_rd && !mem_stall) pend_q.push_back('{own, cyc + 2});
    exp_err = ill; exp_rv0 = nv0; exp_rv1 = nv1;

    if (own >= 0) begin
      if (!ill && !o_req) begin rel = own; own = -1; end
    end else if (rel >= 0) begin
      if (!busy) begin
        x_req = (rel == 0) ? req1 : req0;
        r_req = (rel == 0) ? req0 : req1;
        if (x_req) begin own = 1 - rel; last = own; end
        else if (r_req) begin own = rel; last = own; end
        rel = -1;
      end
    end else begin
      if (req0 && req1) begin own = 1 - last; last = own; end
      else if (req0) begin own = 0; last = 0; end
      else if (req1) begin own = 1; last = 1; end
    end

    @(posedge clk); #1; cyc++;
    check("gnt0", gnt0, own == 0);
    check("gnt1", gnt1, own == 1);
    check("rvalid0", rvalid0, exp_rv0);
    check("rvalid1", rvalid1, exp_rv1);
    check("rdata0", rdata0, exp_rdata0);
    check("rdata1", rdata1, exp_rdata1);
    check("err", err, exp_err);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_rvalid", {rvalid0, rvalid1}, 0);
    check("rst_err", err, 0);
    check("rst_rdata", {rdata0, rdata1}, 0);
    check("rst_mem_cmd", {mem_rd, mem_wr}, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic wait_gnt(input int p);
    int n = 0;
    while ((p == 0 ? gnt0 : gnt1) !== 1'b1 && n < 8) begin step(); n++; end
    check("wait_gnt", (p == 0) ? gnt0 : gnt1, 1);
  endtask

  initial begin
    int rv_at, g_at, c;
    {req0, req1, rd0, rd1, wr0, wr1, mem_stall} = '0;
    {addr0, addr1, wdata0, wdata1, mem_rdata} = '0;
    cyc = 0; wr_acc_cnt = 0;
    model_reset();
    #2;
    do_reset();

    // Single read from port 0
    req0 = 1; step();
    check("t1_gnt0", gnt0, 1);
    rd0 = 1; addr0 = 16'h1230; step();
    rd0 = 0; step();
    mem_rdata = 16'hBEEF; step();
    check("t1_rvalid0", rvalid0, 1);
    check("t1_rdata0", rdata0, 16'hBEEF);
    check("t1_rvalid1", rvalid1, 0);
    mem_rdata = '0; req0 = 0; step(); step();

    // Tie break from reset and switch latency
    do_reset();
    req0 = 1; req1 = 1; step();
    check("t2_first_gnt0", gnt0, 1);
    check("t2_first_gnt1", gnt1, 0);
    step();
    req0 = 0;
    g_at = 0;
    while (gnt1 !== 1'b1 && g_at < 6) begin step(); g_at++; end
    check("t2_gnt1", gnt1, 1);
    check("t2_lat_le3", g_at <= 3, 1);
    req1 = 0; step(); step();
    req0 = 1; req1 = 1; step();
    check("t2_tie2_gnt0", gnt0, 1);

    // Stalled write from port 1
    req0 = 0; wait_gnt(1);
    wr1 = 1; addr1 = 16'h00F8; wdata1 = 16'h5A5A; mem_stall = 1; wr_acc_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t3_stall1", stall1, 1);
      check("t3_mem_wr", mem_wr, 1);
      check("t3_mem_addr", mem_addr, 16'h00F8);
      step();
    end
    mem_stall = 0; step();
    wr1 = 0; step();
    check("t3_one_write", wr_acc_cnt, 1);

    // Read then release: data goes to port 0 before port 1 is granted
    req1 = 0; req0 = 1; wait_gnt(0);
    rd0 = 1; addr0 = 16'h0040; step();
    rd0 = 0; req0 = 0; req1 = 1; step();
    mem_rdata = 16'hCAFE; rv_at = -1; g_at = -1;
    for (int k = 0; k < 6; k++) begin
      step();
      if (rvalid0 === 1'b1 && rv_at < 0) rv_at = k;
      if (gnt1 === 1'b1) begin g_at = k; break; end
    end
    check("t4_gnt1", gnt1, 1);
    check("t4_rdata0", rdata0, 16'hCAFE);
    check("t4_order", (rv_at >= 0) && (rv_at < g_at), 1);

    // Illegal command and foreign command
    req1 = 0; req0 = 1; wait_gnt(0);
    rd0 = 1; wr0 = 1; rd1 = 1;
    #1;
    check("t5_mem_rd", mem_rd, 0);
    check("t5_mem_wr", mem_wr, 0);
    check("t5_stall1", stall1, 1);
    step();
    check("t5_err", err, 1);
    check("t5_hold_gnt0", gnt0, 1);
    rd0 = 0; wr0 = 0; rd1 = 0; step();
    check("t5_err_clr", err, 0);

    // Reset with a read in flight
    rd0 = 1; addr0 = 16'h0100; step();
    rd0 = 0; req0 = 0;
    do_reset();
    mem_rdata = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t6_no_rvalid0", rvalid0, 0);
    end
    check("t6_idle", {gnt0, gnt1}, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      if ($urandom_range(0, 7) == 0) req0 = ~req0;
      if ($urandom_range(0, 7) == 0) req1 = ~req1;
      c = int'($urandom_range(0, 9));
      rd0 = (c >= 4 && c <= 6) || c == 9;
      wr0 = (c >= 7);
      c = int'($urandom_range(0, 9));
      rd1 = (c >= 4 && c <= 6) || c == 9;
      wr1 = (c >= 7);
      addr0 = 16'($urandom); addr1 = 16'($urandom);
      wdata0 = 16'($urandom); wdata1 = 16'($urandom);
      mem_stall = ($urandom_range(0, 3) == 0);
      mem_rdata = 16'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 req0, req1  input  1 each  requester p (0 = instruction cache controller, 1 = data cache controller) wants the memory.
REQ-005 rd0, rd1 / wr0, wr1  input  1 each  memory read / write command from requester p, valid only while gnt_p=1.
REQ-006 addr0, addr1  input  16 each  word address from requester p.
REQ-007 wdata0, wdata1  input  16 each  write data from requester p.
REQ-008 gnt0, gnt1  output  1 each  registered grant; one-hot or zero.
REQ-009 stall0, stall1  output  1 each  command not accepted this cycle; requester holds command.
REQ-010 rdata0, rdata1  output  16 each  read return data.
REQ-011 rvalid0, rvalid1  output  1 each  rdata_p valid this cycle.
REQ-012 mem_addr, mem_wdata  output  16 each  to four-bank memory.
REQ-013 mem_rd, mem_wr  output  1 each  memory command strobes.
REQ-014 mem_rdata  input  16  memory read data, valid exactly 2 cycles after an accepted read.
REQ-015 mem_stall  input  1  memory busy; command presented this cycle not accepted.
REQ-016 err  output  1  one-cycle pulse on illegal command.

Function
REQ-017 SHALL implement FSM states IDLE, GNT0, GNT1, DRAIN; encoding from shared package.
REQ-018 IDLE: sample req0/req1; single request -> GNT_p next cycle; both -> port not in last_gnt pointer; none -> stay IDLE.
REQ-019 last_gnt SHALL be a 1-bit register updated on entry to GNT_p; reset value selects port 0 as first winner.
REQ-020 GNT_p: mem_rd=rd_p&gnt_p, mem_wr=wr_p&gnt_p, mem_addr=addr_p, mem_wdata=wdata_p combinationally; non-granted port's commands ignored, its stall_q=1 when it drives rd or wr.
REQ-021 Command accepted when gnt_p & (rd_p^wr_p) & !mem_stall; stall_p=mem_stall while granted.
REQ-022 rd_p & wr_p together while granted: no memory strobe, err=1 one cycle, state unchanged.
REQ-023 GNT_p holds while req_p=1 (grant spans whole line fill/writeback); req_p=0 -> DRAIN.
REQ-024 Each accepted read SHALL push owner tag into a 2-stage pipe; tag emerging with valid routes mem_rdata to rdata_tag and pulses rvalid_tag; other rdata held at last value.
REQ-025 DRAIN: no new commands; exit when read pipe empty (at most 2 cycles): to GNT of other port if its req=1, else GNT_p if req_p reasserted, else IDLE.
REQ-026 Grant switch latency SHALL be at most 3 cycles from owner dropping req to other gnt rising.
REQ-027 Reads in flight SHALL be delivered to original owner even if grant has moved.
REQ-028 Outside GNT states mem_rd=mem_wr=0; mem_addr/mem_wdata don't-care.

Reset
REQ-029 On rst=0: state=IDLE, last_gnt=1, read pipe cleared, in-flight reads discarded, gnt*, rvalid*, err, mem_rd, mem_wr=0, rdata*=0.
REQ-030 Reset release mid-transfer SHALL resume from IDLE with no spurious rvalid.

Structure
REQ-031 Package mem_arb_pkg SHALL hold state encoding, MEM_RD_LAT=2, NUM_PORTS=2.
REQ-032 Read-return tag pipe SHALL be sub-module rd_tag_pipe (depth MEM_RD_LAT, 1-bit valid + 1-bit owner).
REQ-033 Target 150-300 lines RTL total.

Verification
REQ-034 req0 only, rd0 addr0=0x1230 accepted; mem_rdata=0xBEEF 2 cycles later -> rvalid0=1, rdata0=0xBEEF, rvalid1=0.
REQ-035 req0, req1 rise same cycle from reset -> gnt0 first; after req0 drops -> gnt1 within 3 cycles; next tie -> gnt0.
REQ-036 gnt1, wr1 addr1=0x00F8 with mem_stall=1 for 3 cycles -> stall1=1, mem_wr held, exactly one write accepted when stall falls.
REQ-037 gnt0 issues read then drops req0 next cycle while req1=1 -> DRAIN, rdata to port 0, gnt1 only after rvalid0.
REQ-038 gnt0 with rd0=wr0=1 -> err pulse, mem_rd=mem_wr=0; rd1 while gnt0 -> stall1=1, no memory op.
REQ-039 rst low one cycle after accepted read -> no rvalid in following cycles, gnt0=gnt1=0, state IDLE.
